// File: rtl/etx_arb_if.sv
// etx_arb_if: bundles the three TX FIFO streams, the far-end pushback and
// the merged emesh output of the elink TX arbiter.
//
// Signals (the slave modport is the arbiter's view):
//   txrr_access/packet -> txrr_wait   read-response stream
//   txrd_access/packet -> txrd_wait   read-request stream
//   txwr_access/packet -> txwr_wait   write stream
//   tx_rd_wait, tx_wr_wait            far-end pushback, already synced to clk
//   etx_access/packet/burst <- etx_wait   merged output to the protocol layer
interface etx_arb_if #(
    parameter int PW = 104
);
    logic          txrr_access;
    logic [PW-1:0] txrr_packet;
    logic          txrr_wait;
    logic          txrd_access;
    logic [PW-1:0] txrd_packet;
    logic          txrd_wait;
    logic          txwr_access;
    logic [PW-1:0] txwr_packet;
    logic          txwr_wait;
    logic          tx_rd_wait;
    logic          tx_wr_wait;
    logic          etx_access;
    logic [PW-1:0] etx_packet;
    logic          etx_burst;
    logic          etx_wait;

    modport slave (
        input  txrr_access, txrr_packet,
        output txrr_wait,
        input  txrd_access, txrd_packet,
        output txrd_wait,
        input  txwr_access, txwr_packet,
        output txwr_wait,
        input  tx_rd_wait, tx_wr_wait,
        output etx_access, etx_packet, etx_burst,
        input  etx_wait
    );

    modport master (
        output txrr_access, txrr_packet,
        input  txrr_wait,
        output txrd_access, txrd_packet,
        input  txrd_wait,
        output txwr_access, txwr_packet,
        input  txwr_wait,
        output tx_rd_wait, tx_wr_wait,
        input  etx_access, etx_packet, etx_burst,
        output etx_wait
    );
endinterface

// File: rtl/etx_arbiter.sv
// etx_arbiter: merges the elink TX read-response, read-request and write
// streams into one registered emesh stream and flags double-word bursts.
//
// Ports: clk, reset (synchronous, active high), bus (etx_arb_if.slave).
// Packet: [0] write, [2:1] datamode, [7:3] ctrlmode, [39:8] dstaddr,
//         [71:40] data, [103:72] srcaddr.
// Build option: define ETX_RR_ARB_EN for round-robin rr -> rd -> wr
// arbitration; otherwise fixed priority rr > rd > wr.
module etx_arbiter #(
    parameter int          PW = 104,
    parameter logic [11:0] ID = 12'h999
) (
    input logic    clk,
    input logic    reset,
    etx_arb_if.slave bus
);

    typedef enum logic {
        S_IDLE,
        S_BURST
    } burst_state_t;

    burst_state_t state_q;
    burst_state_t state_d;

    // ID only describes which reads would target this link itself; such
    // packets are passed through untouched, so it drives no logic.
    logic unused_id;
    assign unused_id = ^ID;

    logic          acc_q;
    logic [PW-1:0] pkt_q;
    logic          burst_q;

    logic stall;
    logic el_rr;
    logic el_rd;
    logic el_wr;
    logic lock;
    logic gnt_rr;
    logic gnt_rd;
    logic gnt_wr;
    logic any_gnt;
    logic wr_chain;
    logic burst_hit;
    logic [PW-1:0] gnt_pkt;

    // A held output blocks every source until the protocol layer takes it.
    assign stall = acc_q & bus.etx_wait;

    // Read responses travel as writes on the link, so they obey wr pushback.
    assign el_rr = bus.txrr_access & ~bus.tx_wr_wait & ~stall & ~reset;
    assign el_rd = bus.txrd_access & ~bus.tx_rd_wait & ~stall & ~reset;
    assign el_wr = bus.txwr_access & ~bus.tx_wr_wait & ~stall & ~reset;

    // Once a burst has started, keep feeding it from txwr while data is there.
    assign lock = (state_q == S_BURST) & bus.txwr_access;

`ifdef ETX_RR_ARB_EN
    typedef enum logic [1:0] {
        P_RR,
        P_RD,
        P_WR
    } ptr_t;

    ptr_t ptr_q;
    ptr_t ptr_d;

    always_comb begin
        gnt_rr = 1'b0;
        gnt_rd = 1'b0;
        gnt_wr = 1'b0;
        if (lock) begin
            gnt_wr = el_wr;
        end else begin
            unique case (ptr_q)
                P_RR: begin
                    gnt_rr = el_rr;
                    gnt_rd = el_rd & ~el_rr;
                    gnt_wr = el_wr & ~el_rr & ~el_rd;
                end
                P_RD: begin
                    gnt_rd = el_rd;
                    gnt_wr = el_wr & ~el_rd;
                    gnt_rr = el_rr & ~el_rd & ~el_wr;
                end
                P_WR: begin
                    gnt_wr = el_wr;
                    gnt_rr = el_rr & ~el_wr;
                    gnt_rd = el_rd & ~el_wr & ~el_rr;
                end
                default: begin
                    gnt_rr = el_rr;
                    gnt_rd = el_rd & ~el_rr;
                    gnt_wr = el_wr & ~el_rr & ~el_rd;
                end
            endcase
        end
    end

    // Pointer moves to the source after whichever one was served.
    always_comb begin
        ptr_d = ptr_q;
        unique case (1'b1)
            gnt_rr:  ptr_d = P_RD;
            gnt_rd:  ptr_d = P_WR;
            gnt_wr:  ptr_d = P_RR;
            default: ptr_d = ptr_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= P_RR;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        gnt_rr = 1'b0;
        gnt_rd = 1'b0;
        gnt_wr = 1'b0;
        if (lock) begin
            gnt_wr = el_wr;
        end else begin
            gnt_rr = el_rr;
            gnt_rd = el_rd & ~el_rr;
            gnt_wr = el_wr & ~el_rr & ~el_rd;
        end
    end
`endif

    assign any_gnt = gnt_rr | gnt_rd | gnt_wr;

    always_comb begin
        gnt_pkt = '0;
        unique case (1'b1)
            gnt_rr:  gnt_pkt = bus.txrr_packet;
            gnt_rd:  gnt_pkt = bus.txrd_packet;
            gnt_wr:  gnt_pkt = bus.txwr_packet;
            default: gnt_pkt = '0;
        endcase
    end

    // A double-word write continues the chain when it follows the last
    // issued packet by 8 bytes with the same ctrlmode; the 32-bit add wraps.
    assign wr_chain = bus.txwr_packet[0]
                    & (bus.txwr_packet[2:1] == 2'b11)
                    & (bus.txwr_packet[7:3] == pkt_q[7:3])
                    & (bus.txwr_packet[39:8] == pkt_q[39:8] + 32'd8);

    assign burst_hit = gnt_wr & wr_chain;

    // Burst state only moves when a new packet could be issued; any cycle
    // that is not a chained write grant ends the burst.
    always_comb begin
        state_d = state_q;
        if (!stall) begin
            state_d = burst_hit ? S_BURST : S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q   <= 1'b0;
            pkt_q   <= '0;
            burst_q <= 1'b0;
        end else if (any_gnt) begin
            acc_q   <= 1'b1;
            pkt_q   <= gnt_pkt;
            burst_q <= burst_hit;
        end else if (!bus.etx_wait) begin
            acc_q   <= 1'b0;
            burst_q <= 1'b0;
        end
    end

    assign bus.txrr_wait  = reset | ~gnt_rr;
    assign bus.txrd_wait  = reset | ~gnt_rd;
    assign bus.txwr_wait  = reset | ~gnt_wr;
    assign bus.etx_access = acc_q;
    assign bus.etx_packet = pkt_q;
    assign bus.etx_burst  = burst_q;

endmodule

// File: tb/tb_etx_arbiter.sv
// tb_etx_arbiter: directed vector table plus a short throughput sequence
// for etx_arbiter in its default fixed-priority build.
module tb_etx_arbiter;

    localparam int PW = 104;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    etx_arb_if #(.PW(PW)) bus ();

    etx_arbiter #(.PW(PW), .ID(12'h999)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        string         name;
        logic          rst;
        logic          ra;
        logic          da;
        logic          wa;
        logic [PW-1:0] rp;
        logic [PW-1:0] dp;
        logic [PW-1:0] wp;
        logic          trw;
        logic          tww;
        logic          ew;
        logic          xrw;
        logic          xdw;
        logic          xww;
        logic          xacc;
        logic [PW-1:0] xpkt;
        logic          xb;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [PW-1:0] mk(logic w, logic [1:0] dm,
                                         logic [4:0] cm, logic [31:0] dst,
                                         logic [31:0] dat);
        return {32'h0000_00A5, dat, dst, cm, dm, w};
    endfunction

    function automatic vec_t v(string n, logic rst, logic ra, logic da,
                               logic wa, logic [PW-1:0] rp,
                               logic [PW-1:0] dp, logic [PW-1:0] wp,
                               logic trw, logic tww, logic ew, logic xrw,
                               logic xdw, logic xww, logic xacc,
                               logic [PW-1:0] xpkt, logic xb);
        vec_t t;
        t.name = n;  t.rst = rst; t.ra = ra;   t.da = da;   t.wa = wa;
        t.rp = rp;   t.dp = dp;   t.wp = wp;   t.trw = trw; t.tww = tww;
        t.ew = ew;   t.xrw = xrw; t.xdw = xdw; t.xww = xww;
        t.xacc = xacc; t.xpkt = xpkt; t.xb = xb;
        return t;
    endfunction

    task automatic chk(string n, string f, logic [PW-1:0] act,
                       logic [PW-1:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s %s: got %h want %h", n, f, act, exp);
        end
    endtask

    logic [PW-1:0] rr, rd, wr, abcd, z;
    logic [PW-1:0] b0, b1, b2, b3, b4, b5;
    logic [PW-1:0] w0, w1, w2, w3, w4, w5;

    initial begin
        z    = '0;
        rr   = mk(1'b1, 2'd2, 5'd0, 32'h0000_1000, 32'hAAAA_0001);
        rd   = mk(1'b0, 2'd2, 5'd0, 32'h0000_2000, 32'h0);
        wr   = mk(1'b1, 2'd2, 5'd0, 32'h0000_3000, 32'h5555_0000);
        abcd = mk(1'b1, 2'd2, 5'd0, 32'h0000_4000, 32'h0000_ABCD);
        b0   = mk(1'b1, 2'd3, 5'd0, 32'h8000_0000, 32'd0);
        b1   = mk(1'b1, 2'd3, 5'd0, 32'h8000_0008, 32'd1);
        b2   = mk(1'b1, 2'd3, 5'd0, 32'h8000_0010, 32'd2);
        b3   = mk(1'b1, 2'd3, 5'd0, 32'h8000_0018, 32'd3);
        b4   = mk(1'b1, 2'd3, 5'd1, 32'h8000_0020, 32'd4);
        b5   = mk(1'b1, 2'd3, 5'd1, 32'h8000_0028, 32'd5);
        w0   = mk(1'b1, 2'd3, 5'd0, 32'hFFFF_FFF0, 32'd10);
        w1   = mk(1'b1, 2'd3, 5'd0, 32'hFFFF_FFF8, 32'd11);
        w2   = mk(1'b1, 2'd3, 5'd0, 32'h0000_0000, 32'd12);
        w3   = mk(1'b1, 2'd3, 5'd0, 32'h0000_0008, 32'd13);
        w4   = mk(1'b1, 2'd3, 5'd0, 32'h0000_0010, 32'd14);
        w5   = mk(1'b1, 2'd3, 5'd0, 32'h0000_0018, 32'd15);

        //            name     rst ra da wa rp  dp  wp   trw tww ew  xrw xdw xww acc pkt  b
        vq.push_back(v("rst0", 1, 1, 1, 1, rr, rd, wr,   0, 0, 0,  1, 1, 1,  0, z,    0));
        vq.push_back(v("rst1", 1, 1, 1, 1, rr, rd, wr,   0, 0, 0,  1, 1, 1,  0, z,    0));
        vq.push_back(v("rst2", 1, 1, 1, 1, rr, rd, wr,   0, 0, 0,  1, 1, 1,  0, z,    0));
        vq.push_back(v("ord_rr", 0, 1, 1, 1, rr, rd, wr, 0, 0, 0,  0, 1, 1,  1, rr,   0));
        vq.push_back(v("ord_rd", 0, 0, 1, 1, rr, rd, wr, 0, 0, 0,  1, 0, 1,  1, rd,   0));
        vq.push_back(v("ord_wr", 0, 0, 0, 1, rr, rd, wr, 0, 0, 0,  1, 1, 0,  1, wr,   0));
        vq.push_back(v("idle",  0, 0, 0, 0, rr, rd, wr,  0, 0, 0,  1, 1, 1,  0, z,    0));
        vq.push_back(v("rdw_wr", 0, 0, 1, 1, rr, rd, wr, 1, 0, 0,  1, 1, 0,  1, wr,   0));
        vq.push_back(v("rdw_blk", 0, 0, 1, 0, rr, rd, wr, 1, 0, 0, 1, 1, 1,  0, z,    0));
        vq.push_back(v("rdw_rel", 0, 0, 1, 0, rr, rd, wr, 0, 0, 0, 1, 0, 1,  1, rd,   0));
        vq.push_back(v("b0",    0, 0, 0, 1, rr, rd, b0,  0, 0, 0,  1, 1, 0,  1, b0,   0));
        vq.push_back(v("b1",    0, 0, 0, 1, rr, rd, b1,  0, 0, 0,  1, 1, 0,  1, b1,   1));
        vq.push_back(v("b2lock", 0, 1, 1, 1, rr, rd, b2, 0, 0, 0,  1, 1, 0,  1, b2,   1));
        vq.push_back(v("b3lock", 0, 1, 0, 1, rr, rd, b3, 0, 0, 0,  1, 1, 0,  1, b3,   1));
        vq.push_back(v("b4cm",  0, 1, 0, 1, rr, rd, b4,  0, 0, 0,  1, 1, 0,  1, b4,   0));
        vq.push_back(v("b_idle", 0, 1, 0, 1, rr, rd, b5, 0, 0, 0,  0, 1, 1,  1, rr,   0));
        vq.push_back(v("b5",    0, 0, 0, 1, rr, rd, b5,  0, 0, 0,  1, 1, 0,  1, b5,   0));
        vq.push_back(v("abcd",  0, 0, 0, 1, rr, rd, abcd, 0, 0, 0, 1, 1, 0,  1, abcd, 0));
        for (int i = 0; i < 5; i++)
            vq.push_back(v("ewait", 0, 1, 1, 1, rr, rd, wr, 0, 0, 1, 1, 1, 1, 1, abcd, 0));
        vq.push_back(v("ew_rel", 0, 1, 1, 1, rr, rd, wr, 0, 0, 0,  0, 1, 1,  1, rr,   0));
        vq.push_back(v("both0", 0, 1, 1, 1, rr, rd, wr,  1, 1, 0,  1, 1, 1,  0, z,    0));
        vq.push_back(v("both1", 0, 1, 1, 1, rr, rd, wr,  1, 1, 0,  1, 1, 1,  0, z,    0));
        vq.push_back(v("wrw_rd", 0, 1, 1, 1, rr, rd, wr, 0, 1, 0,  1, 0, 1,  1, rd,   0));
        vq.push_back(v("w0",    0, 0, 0, 1, rr, rd, w0,  0, 0, 0,  1, 1, 0,  1, w0,   0));
        vq.push_back(v("w1",    0, 0, 0, 1, rr, rd, w1,  0, 0, 0,  1, 1, 0,  1, w1,   1));
        vq.push_back(v("w2wrap", 0, 0, 0, 1, rr, rd, w2, 0, 0, 0,  1, 1, 0,  1, w2,   1));
        vq.push_back(v("rst_mid", 1, 1, 0, 1, rr, rd, w3, 0, 0, 0, 1, 1, 1,  0, z,    0));
        vq.push_back(v("post_rst", 0, 1, 0, 1, rr, rd, w3, 0, 0, 0, 0, 1, 1, 1, rr,   0));
        vq.push_back(v("w3",    0, 0, 0, 1, rr, rd, w3,  0, 0, 0,  1, 1, 0,  1, w3,   0));
        vq.push_back(v("w4",    0, 0, 0, 1, rr, rd, w4,  0, 0, 0,  1, 1, 0,  1, w4,   1));
        vq.push_back(v("bst_ew", 0, 1, 0, 1, rr, rd, w5, 0, 0, 1,  1, 1, 1,  1, w4,   1));
        vq.push_back(v("bst_lk", 0, 1, 0, 1, rr, rd, w5, 0, 0, 0,  1, 1, 0,  1, w5,   1));
        vq.push_back(v("drain", 0, 0, 0, 0, rr, rd, w5,  0, 0, 0,  1, 1, 1,  0, z,    0));

        reset = 1'b1;
        bus.txrr_access = 1'b0; bus.txrr_packet = '0;
        bus.txrd_access = 1'b0; bus.txrd_packet = '0;
        bus.txwr_access = 1'b0; bus.txwr_packet = '0;
        bus.tx_rd_wait = 1'b0;  bus.tx_wr_wait = 1'b0;
        bus.etx_wait = 1'b0;

        foreach (vq[i]) begin
            @(negedge clk);
            reset = vq[i].rst;
            bus.txrr_access = vq[i].ra; bus.txrr_packet = vq[i].rp;
            bus.txrd_access = vq[i].da; bus.txrd_packet = vq[i].dp;
            bus.txwr_access = vq[i].wa; bus.txwr_packet = vq[i].wp;
            bus.tx_rd_wait = vq[i].trw; bus.tx_wr_wait = vq[i].tww;
            bus.etx_wait = vq[i].ew;
            #1;
            chk(vq[i].name, "txrr_wait", PW'(bus.txrr_wait), PW'(vq[i].xrw));
            chk(vq[i].name, "txrd_wait", PW'(bus.txrd_wait), PW'(vq[i].xdw));
            chk(vq[i].name, "txwr_wait", PW'(bus.txwr_wait), PW'(vq[i].xww));
            @(posedge clk);
            #1;
            chk(vq[i].name, "etx_access", PW'(bus.etx_access), PW'(vq[i].xacc));
            chk(vq[i].name, "etx_burst", PW'(bus.etx_burst), PW'(vq[i].xb));
            if (vq[i].xacc || vq[i].rst)
                chk(vq[i].name, "etx_packet", bus.etx_packet, vq[i].xpkt);
            n_vec++;
        end

        // Back-to-back single writes: one packet per cycle, no burst flag.
        for (int k = 0; k < 6; k++) begin
            logic [PW-1:0] p;
            p = mk(1'b1, 2'd2, 5'd0, 32'h5000 + 32'(k * 4), 32'(k));
            @(negedge clk);
            reset = 1'b0;
            bus.txrr_access = 1'b0; bus.txrd_access = 1'b0;
            bus.txwr_access = 1'b1; bus.txwr_packet = p;
            bus.tx_rd_wait = 1'b0; bus.tx_wr_wait = 1'b0; bus.etx_wait = 1'b0;
            #1;
            chk("tput", "txwr_wait", PW'(bus.txwr_wait), PW'(1'b0));
            @(posedge clk);
            #1;
            chk("tput", "etx_access", PW'(bus.etx_access), PW'(1'b1));
            chk("tput", "etx_packet", bus.etx_packet, p);
            chk("tput", "etx_burst", PW'(bus.etx_burst), PW'(1'b0));
            n_vec++;
        end
        @(negedge clk);
        bus.txwr_access = 1'b0;
        @(posedge clk);
        #1;
        chk("tput_end", "etx_access", PW'(bus.etx_access), PW'(1'b0));
        n_vec++;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
